// File: rtl/spi_slave_if.sv
// CPU-side register bus of the SPI responder: byte-addressed write/read strobes,
// registered read data and the level interrupt.
interface spi_slave_if;
   logic [4:0]  wr_addr;
   logic        wr_en;
   logic [31:0] wr_data;
   logic [3:0]  wr_strb;
   logic [4:0]  rd_addr;
   logic        rd_en;
   logic [31:0] rd_data;
   logic        irq;

   modport master (
      output wr_addr, wr_en, wr_data, wr_strb, rd_addr, rd_en,
      input  rd_data, irq
   );

   modport slave (
      input  wr_addr, wr_en, wr_data, wr_strb, rd_addr, rd_en,
      output rd_data, irq
   );
endinterface

// File: rtl/spi_slave.sv
// SPI mode-0 responder, MSB first: one TX holding word, one RX word,
// status flags with overrun/underrun detection and a level interrupt.
module spi_slave #(
   parameter int DATA_W      = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   spi_slave_if.slave bus,
   input  logic       spi_sclk,
   input  logic       spi_cs_n,
   input  logic       spi_mosi,
   output logic       spi_miso
);
   localparam int CNT_W = $clog2(DATA_W + 1);

   typedef enum logic {IDLE, SHIFT} state_t;
   state_t state, state_nxt;

   logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
   logic                   sclk_prev, cs_prev;
   logic                   sclk_rise, sclk_fall, cs_rise, cs_fall, mosi_s;

   logic [3:0]        ctrl;
   logic [DATA_W-1:0] tx_hold, tx_shift, rx_data, rx_word, tx_load_val;
   logic [DATA_W-2:0] rx_shift;
   logic [CNT_W-1:0]  bitcnt;
   logic              rxf, txe, ovr, udr, reload_pend, udr_pend;
   logic              en, start, word_end, reload, udr_commit, tx_load;
   logic              tx_wr, st_wr, ctrl_wr, rx_rd;
   logic [31:0]       status;
   logic              unused;

   // cs_n resets to "selected" so a pin already low at reset release never looks like a new falling edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sclk_sync <= '0;
         cs_sync   <= '0;
         mosi_sync <= '0;
         sclk_prev <= 1'b0;
         cs_prev   <= 1'b0;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
         cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
         sclk_prev <= sclk_sync[SYNC_STAGES-1];
         cs_prev   <= cs_sync[SYNC_STAGES-1];
      end
   end

   assign sclk_rise = sclk_sync[SYNC_STAGES-1] & ~sclk_prev;
   assign sclk_fall = ~sclk_sync[SYNC_STAGES-1] & sclk_prev;
   assign cs_rise   = cs_sync[SYNC_STAGES-1] & ~cs_prev;
   assign cs_fall   = ~cs_sync[SYNC_STAGES-1] & cs_prev;
   assign mosi_s    = mosi_sync[SYNC_STAGES-1];

   assign en      = ctrl[3];
   assign tx_wr   = bus.wr_en && bus.wr_addr[4:2] == 3'd0;
   assign st_wr   = bus.wr_en && bus.wr_addr[4:2] == 3'd2 && bus.wr_strb[0];
   assign ctrl_wr = bus.wr_en && bus.wr_addr[4:2] == 3'd3 && bus.wr_strb[0];
   assign rx_rd   = bus.rd_en && bus.rd_addr[4:2] == 3'd1;
   assign unused  = ^{bus.wr_addr[1:0], bus.rd_addr[1:0], bus.wr_data, bus.wr_strb};

   assign rx_word     = {rx_shift, mosi_s};
   assign tx_load_val = txe ? '1 : tx_hold;
   assign tx_load     = start | reload;
   assign status      = {27'b0, state == SHIFT, udr, ovr, txe, rxf};
   assign spi_miso    = (state == SHIFT) ? tx_shift[DATA_W-1] : 1'b1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // NOTE: every output of this block gets a default first so no path can infer a latch.
   always_comb begin
      state_nxt  = state;
      start      = 1'b0;
      word_end   = 1'b0;
      reload     = 1'b0;
      udr_commit = 1'b0;
      case (state)
         IDLE: begin
            if (en && cs_fall) begin
               state_nxt = SHIFT;
               start     = 1'b1;
            end
         end
         SHIFT: begin
            if (!en || cs_rise) begin
               state_nxt = IDLE;
            end else begin
               word_end   = sclk_rise && bitcnt == CNT_W'(DATA_W - 1);
               udr_commit = sclk_rise && udr_pend;
               reload     = sclk_fall && reload_pend;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // A word-end reload is applied on the next SCLK fall; its underrun is only reported
   // once the master actually clocks the first bit of that word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_shift    <= '1;
         rx_shift    <= '0;
         bitcnt      <= '0;
         reload_pend <= 1'b0;
         udr_pend    <= 1'b0;
      end else if (start) begin
         tx_shift    <= tx_load_val;
         bitcnt      <= '0;
         reload_pend <= 1'b0;
         udr_pend    <= 1'b0;
      end else if (state == SHIFT && state_nxt == SHIFT) begin
         if (sclk_rise) begin
            rx_shift <= rx_word[DATA_W-2:0];
            bitcnt   <= word_end ? '0 : bitcnt + 1'b1;
            udr_pend <= 1'b0;
            if (word_end) reload_pend <= 1'b1;
         end
         if (sclk_fall) begin
            if (reload_pend) begin
               tx_shift    <= tx_load_val;
               udr_pend    <= txe;
               reload_pend <= 1'b0;
            end else begin
               tx_shift <= {tx_shift[DATA_W-2:0], 1'b1};
            end
         end
      end else begin
         bitcnt      <= '0;
         reload_pend <= 1'b0;
         udr_pend    <= 1'b0;
      end
   end

   // Flag sets take priority over CPU clears; a TXDATA write beats a TX load.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ctrl    <= '0;
         tx_hold <= '0;
         rx_data <= '0;
         rxf     <= 1'b0;
         txe     <= 1'b1;
         ovr     <= 1'b0;
         udr     <= 1'b0;
      end else begin
         if (ctrl_wr) ctrl <= bus.wr_data[3:0];
         if (tx_wr) begin
            for (int i = 0; i < DATA_W; i++)
               if (bus.wr_strb[i/8]) tx_hold[i] <= bus.wr_data[i];
         end
         if (tx_wr)        txe <= 1'b0;
         else if (tx_load) txe <= 1'b1;
         if (word_end) rx_data <= rx_word;
         if (word_end)   rxf <= 1'b1;
         else if (rx_rd) rxf <= 1'b0;
         if (word_end && rxf && !rx_rd)  ovr <= 1'b1;
         else if (st_wr && bus.wr_data[2]) ovr <= 1'b0;
         if ((start && txe) || udr_commit) udr <= 1'b1;
         else if (st_wr && bus.wr_data[3]) udr <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.rd_data <= '0;
         bus.irq     <= 1'b0;
      end else begin
         bus.irq <= (ctrl[0] & rxf) | (ctrl[1] & txe) | (ctrl[2] & (ovr | udr));
         if (bus.rd_en) begin
            case (bus.rd_addr[4:2])
               3'd1:    bus.rd_data <= 32'(rx_data);
               3'd2:    bus.rd_data <= status;
               3'd3:    bus.rd_data <= {28'b0, ctrl};
               default: bus.rd_data <= '0;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: drives the SPI pins as a mode-0 master and the register
// bus as a CPU, comparing MISO bits and register reads against a scoreboard queue.
`timescale 1ns/1ps
module tb_spi_slave;
   localparam int HALF = 5;   // clk cycles per SCLK half period

   localparam logic [4:0] A_TX = 5'h00, A_RX = 5'h04, A_ST = 5'h08, A_CTRL = 5'h0C, A_RES = 5'h14;

   logic clk = 1'b0;
   logic rst;
   logic spi_sclk, spi_cs_n, spi_mosi, spi_miso;

   spi_slave_if bus ();

   spi_slave #(.DATA_W(8), .SYNC_STAGES(2)) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .spi_sclk (spi_sclk),
      .spi_cs_n (spi_cs_n),
      .spi_mosi (spi_mosi),
      .spi_miso (spi_miso)
   );

   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_pop(input string tag, input logic [31:0] obs);
      logic [31:0] e;
      if (exp_q.size() == 0) begin
         n_cmp++;
         n_err++;
         $error("FAIL %s: observed %h expected <nothing queued>", tag, obs);
      end else begin
         e = exp_q.pop_front();
         check(tag, obs, e);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      bus.wr_addr = a;
      bus.wr_data = d;
      bus.wr_strb = 4'hF;
      bus.wr_en   = 1'b1;
      @(negedge clk);
      bus.wr_en   = 1'b0;
   endtask

   task automatic rd_check(input string tag, input logic [4:0] a, input logic [31:0] e);
      exp_q.push_back(e);
      bus.rd_addr = a;
      bus.rd_en   = 1'b1;
      @(negedge clk);
      bus.rd_en   = 1'b0;
      check_pop(tag, bus.rd_data);
   endtask

   // Shifts nbits of mosi_w (MSB first) and checks each MISO bit just before its rising edge.
   // With rd_at_end set, RXDATA is read in the very cycle the DUT sees the last rising edge.
   task automatic spi_word(input string tag, input logic [7:0] mosi_w, input logic [7:0] miso_w,
                           input int nbits, input bit rd_at_end, input logic [31:0] rd_exp);
      for (int b = 7; b >= 8 - nbits; b--) begin
         spi_mosi = mosi_w[b];
         exp_q.push_back({31'b0, miso_w[b]});
         idle(HALF);
         check_pop(tag, {31'b0, spi_miso});
         spi_sclk = 1'b1;
         if (rd_at_end && b == 0) begin
            idle(2);
            exp_q.push_back(rd_exp);
            bus.rd_addr = A_RX;
            bus.rd_en   = 1'b1;
            @(negedge clk);
            bus.rd_en   = 1'b0;
            check_pop({tag, "_rd"}, bus.rd_data);
            idle(HALF - 3);
         end else begin
            idle(HALF);
         end
         spi_sclk = 1'b0;
      end
   endtask

   task automatic cs_hi();
      idle(HALF);
      spi_cs_n = 1'b1;
      idle(HALF);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst         = 1'b1;
      spi_sclk    = 1'b0;
      spi_cs_n    = 1'b1;
      spi_mosi    = 1'b0;
      bus.wr_addr = '0;
      bus.wr_en   = 1'b0;
      bus.wr_data = '0;
      bus.wr_strb = '0;
      bus.rd_addr = '0;
      bus.rd_en   = 1'b0;
      idle(3);

      // 1: reset state, EN=0 ignores CS, reserved space
      check("rst_miso", {31'b0, spi_miso}, 32'h1);
      check("rst_irq", {31'b0, bus.irq}, 32'h0);
      check("rst_rd_data", bus.rd_data, 32'h0);
      rst = 1'b0;
      idle(4);
      rd_check("rst_status", A_ST, 32'h02);
      rd_check("rst_ctrl", A_CTRL, 32'h0);
      rd_check("rst_rxdata", A_RX, 32'h0);
      spi_cs_n = 1'b0;
      idle(HALF);
      rd_check("en0_status", A_ST, 32'h02);
      check("en0_miso", {31'b0, spi_miso}, 32'h1);
      cs_hi();
      wr(A_RES, 32'hFFFF_FFFF);
      rd_check("reserved", A_RES, 32'h0);

      // 2: single word, TX 0xA5 / RX 0x3C
      wr(A_CTRL, 32'h08);
      wr(A_TX, 32'hA5);
      rd_check("tx_full_status", A_ST, 32'h00);
      spi_cs_n = 1'b0;
      idle(HALF);
      rd_check("busy_status", A_ST, 32'h12);
      spi_word("w2_miso", 8'h3C, 8'hA5, 8, 1'b0, 32'h0);
      cs_hi();
      rd_check("w2_status", A_ST, 32'h03);
      rd_check("w2_rxdata", A_RX, 32'h3C);
      rd_check("w2_status_rd", A_ST, 32'h02);

      // 3: two-word frame with one TX word -> underrun and overrun
      wr(A_TX, 32'h81);
      spi_cs_n = 1'b0;
      spi_word("w3a_miso", 8'h11, 8'h81, 8, 1'b0, 32'h0);
      spi_word("w3b_miso", 8'h22, 8'hFF, 8, 1'b0, 32'h0);
      cs_hi();
      rd_check("w3_status", A_ST, 32'h0F);
      rd_check("w3_rxdata", A_RX, 32'h22);
      wr(A_ST, 32'h0C);
      rd_check("w3_status_clr", A_ST, 32'h02);

      // 4: partial word discarded, next word realigned
      wr(A_TX, 32'h3C);
      spi_cs_n = 1'b0;
      spi_word("w4p_miso", 8'hFF, 8'h3C, 5, 1'b0, 32'h0);
      cs_hi();
      rd_check("w4p_status", A_ST, 32'h02);
      spi_cs_n = 1'b0;
      spi_word("w4_miso", 8'h5A, 8'hFF, 8, 1'b0, 32'h0);
      cs_hi();
      rd_check("w4_status", A_ST, 32'h0B);
      rd_check("w4_rxdata", A_RX, 32'h5A);
      wr(A_ST, 32'h08);
      rd_check("w4_status_clr", A_ST, 32'h02);

      // 5: interrupts and RXDATA read colliding with a word end
      wr(A_CTRL, 32'h0D);
      idle(1);
      check("w5_irq_idle", {31'b0, bus.irq}, 32'h0);
      wr(A_TX, 32'h42);
      spi_cs_n = 1'b0;
      spi_word("w5a_miso", 8'h33, 8'h42, 8, 1'b0, 32'h0);
      cs_hi();
      check("w5_irq_rxf", {31'b0, bus.irq}, 32'h1);
      wr(A_TX, 32'h24);
      spi_cs_n = 1'b0;
      spi_word("w5b_miso", 8'h44, 8'h24, 8, 1'b1, 32'h33);
      cs_hi();
      rd_check("w5_status", A_ST, 32'h03);
      rd_check("w5_rxdata", A_RX, 32'h44);
      check("w5_irq_hold", {31'b0, bus.irq}, 32'h1);
      idle(1);
      check("w5_irq_fall", {31'b0, bus.irq}, 32'h0);

      // 6: reset mid-word with CS held low
      wr(A_TX, 32'hC3);
      spi_cs_n = 1'b0;
      spi_word("w6p_miso", 8'hAA, 8'hC3, 4, 1'b0, 32'h0);
      rst = 1'b1;
      idle(2);
      check("w6_rst_miso", {31'b0, spi_miso}, 32'h1);
      check("w6_rst_irq", {31'b0, bus.irq}, 32'h0);
      check("w6_rst_rd_data", bus.rd_data, 32'h0);
      rst = 1'b0;
      idle(2);
      rd_check("w6_status", A_ST, 32'h02);
      rd_check("w6_ctrl", A_CTRL, 32'h0);
      wr(A_CTRL, 32'h08);
      spi_word("w6_idle_miso", 8'h5A, 8'hFF, 8, 1'b0, 32'h0);
      idle(HALF);
      rd_check("w6_idle_status", A_ST, 32'h02);
      rd_check("w6_idle_rxdata", A_RX, 32'h0);
      cs_hi();
      wr(A_TX, 32'h5A);
      spi_cs_n = 1'b0;
      spi_word("w6_miso", 8'hE7, 8'h5A, 8, 1'b0, 32'h0);
      cs_hi();
      rd_check("w6_rxdata", A_RX, 32'hE7);
      rd_check("w6_status_end", A_ST, 32'h02);

      if (exp_q.size() != 0) begin
         n_cmp++;
         n_err++;
         $error("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
